// File: rtl/timer_pkg.sv
// Shared constants, state encoding and key classification for the timer
// digit-entry front-end.
package timer_pkg;

  localparam int unsigned BCD_W           = 4;
  localparam int unsigned CNT_W           = 2;
  localparam int unsigned NUM_DIGITS      = 3;
  localparam int unsigned BCD_MAX         = 9;
  localparam int unsigned MAX_SEC_TENS    = 5;
  localparam int unsigned KEY_DIGIT_LIMIT = BCD_MAX + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Keypad codes below KEY_DIGIT_LIMIT are decimal digits.
  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return 32'(code) < KEY_DIGIT_LIMIT;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// One-bit rising-edge detector: registers the level once and flags 0->1.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/timer_digit_entry.sv
// Keypad digit-entry register (M:SS) that parallel-loads the downstream
// mod-10 counter chain with a one-cycle load pulse on start.
module timer_digit_entry
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_code,
  input  logic             clear,
  input  logic             start,
  input  logic             timer_busy,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic             load,
  output logic [CNT_W-1:0] digit_count,
  output logic             key_err,
  output logic             entry_active
);

  state_t state;
  logic   key_rise_c;
  logic   start_rise_c;
  logic   key_ok_c;
  logic   start_ok_c;
  logic   key_reject_c;

  edge_detect_rise u_key_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (key_valid),
    .rise_c (key_rise_c)
  );

  edge_detect_rise u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (start),
    .rise_c (start_rise_c)
  );

  // A busy downstream timer masks presses without flagging them as errors.
  assign key_ok_c   = key_rise_c & ~timer_busy;
  assign start_ok_c = start_rise_c & ~timer_busy;

  // Reject when full, non-digit, or when the shift would push an illegal
  // value into the seconds-tens position.
  assign key_reject_c = !is_digit(key_code)
                     || (32'(digit_count) >= NUM_DIGITS)
                     || (32'(sec_ones) > MAX_SEC_TENS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sec_ones     <= '0;
      sec_tens     <= '0;
      min_ones     <= '0;
      digit_count  <= '0;
      load         <= 1'b0;
      key_err      <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      load    <= 1'b0;
      key_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!clear && key_ok_c) begin
            if (is_digit(key_code)) begin
              sec_ones     <= key_code;
              digit_count  <= CNT_W'(1);
              state        <= ENTRY;
              entry_active <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        ENTRY: begin
          if (clear) begin
            sec_ones     <= '0;
            sec_tens     <= '0;
            min_ones     <= '0;
            digit_count  <= '0;
            state        <= IDLE;
            entry_active <= 1'b0;
          end else if (start_ok_c) begin
            load         <= 1'b1;
            state        <= LOAD;
            entry_active <= 1'b0;
          end else if (key_ok_c) begin
            if (key_reject_c) begin
              key_err <= 1'b1;
            end else begin
              min_ones    <= sec_tens;
              sec_tens    <= sec_ones;
              sec_ones    <= key_code;
              digit_count <= digit_count + CNT_W'(1);
            end
          end
        end
        LOAD: begin
          sec_ones    <= '0;
          sec_tens    <= '0;
          min_ones    <= '0;
          digit_count <= '0;
          state       <= IDLE;
        end
        default: begin
          state        <= IDLE;
          entry_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
